mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory/writeback stage directly downstream of the executor in the 16-bit pipelined core.
- Consumes the executor's result (ALU value or effective address) and performs load/store accesses on data port B of the dual-port RAM through a req/ack handshake.
- Produces the registered writeback (enable, dest, value) into the register file.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- DATA_W, 16, data and register value width.
- ADDR_W, 16, memory address width.
- TIMEOUT, 15, cycles without ack before abort; used only with the optional feature.

Ports:
- clk  in  1  pipeline clock; rising edge.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  executor presents an op this cycle.
- ex_op  in  2  operation: 00 ALU writeback, 01 LD, 10 ST, 11 NOP.
- ex_dest  in  3  destination register; 7 means discard.
- ex_value  in  DATA_W  ALU result, or effective address for LD/ST.
- ex_store_data  in  DATA_W  store data (reg_1 path).
- stall  out  1  upstream must hold ex_* stable and not advance.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data; valid when mem_ack is high.
- mem_ack  in  1  access complete this cycle.
- wb_enable  out  1  register-file write strobe (one-cycle pulse).
- wb_dest  out  3  writeback register.
- wb_value  out  DATA_W  writeback data.
- perf_stall_cycles  out  16  saturating count of cycles with stall=1.
- err  out  1  sticky access-timeout flag.

Behaviour:
- States: IDLE, LOAD, STORE.
- Reset: state IDLE; wb_enable, mem_req, mem_we, err, perf_stall_cycles all 0; mem_addr, mem_wdata, wb_value 0; wb_dest 7.
- stall is combinational: stall = (state != IDLE).
- An op is accepted only when stall=0 and ex_valid=1.
- IDLE, ALU op accepted:
  - Next cycle wb_enable=1, wb_dest=ex_dest, wb_value=ex_value.
  - When ex_dest==7, wb_enable stays 0.
  - Latency 1; throughput 1 op/cycle.
- IDLE, LD accepted:
  - Register mem_addr=ex_value[ADDR_W-1:0] and the dest.
  - Next cycle mem_req=1, mem_we=0; state LOAD.
- IDLE, ST accepted:
  - Register mem_addr and mem_wdata=ex_store_data.
  - Next cycle mem_req=1, mem_we=1; state STORE.
- NOP (11) or ex_valid=0: wb_enable=0 next cycle; state unchanged.
- LOAD/STORE:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - On the ack edge: mem_req drops to 0 and state returns to IDLE.
  - LOAD ack: next cycle wb_enable=1 (dest!=7), wb_value=mem_rdata captured at the ack edge.
  - STORE ack: no writeback.
- Minimum LD latency is 2 cycles (accept, then ack in the first request cycle); LD result is visible on cycle 3.
- A new op is accepted the cycle after the ack edge, because stall falls with the return to IDLE.
- mem_ack while IDLE is ignored. mem_ack and its data are sampled only while mem_req=1.
- wb_enable is a single-cycle pulse. No two writebacks ever land in the same cycle.
- perf_stall_cycles increments each cycle stall=1 and saturates at 16'hFFFF (no wrap).
- Reset mid-access: mem_req drops immediately (async) and the pending writeback is discarded. An ack arriving after reset is ignored.

Optional Feature:
- Macro: MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A 4+ bit wait counter clears on entry to LOAD/STORE and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack: mem_req drops, state returns to IDLE, there is no writeback, and err is set.
  - err is sticky until rst.
  - An ack in the same cycle as the timeout wins: normal completion, err not set.
- Not defined: no counter; the stage waits indefinitely for ack; err is tied to 0.

Test Plan:
- Reset, then ALU op ex_dest=3, ex_value=16'h1234 -> next cycle wb_enable=1, wb_dest=3, wb_value=16'h1234, stall=0 throughout.
- ALU op with ex_dest=7 -> wb_enable stays 0.
- LD addr 16'h0040 dest 2, ack after 3 wait cycles with mem_rdata=16'hBEEF:
  - mem_req=1, mem_we=0, mem_addr=16'h0040 held for 4 cycles.
  - stall=1 during the access.
  - wb_value=16'hBEEF to r2 one cycle after ack.
  - perf_stall_cycles=4.
- ST addr 16'h0010 data 16'h00A5, immediate ack -> mem_we=1, mem_wdata=16'h00A5 for 1 cycle, no wb_enable. A back-to-back ALU op is accepted the cycle after ack.
- rst pulsed while in LOAD with mem_req=1 -> mem_req=0 immediately; a later ack with mem_rdata=16'hFFFF produces no writeback.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT=15: LD, no ack for 15 cycles -> mem_req drops, err=1, no writeback; err stays 1 across later ops until rst.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- memory/writeback stage of the 16-bit pipelined core.
//
// Takes the executor's result and either writes it straight back (ALU ops)
// or performs a load/store on RAM port B through a req/ack handshake. The
// writeback is registered, so every writeback is a one-cycle wb_enable pulse.
// While an access is outstanding, stall holds the upstream pipeline.
//
// Optional build macro:
//   MEM_STAGE_TIMEOUT_EN  abort an access after TIMEOUT cycles without ack
//                         and set the sticky err flag. When undefined, the
//                         stage waits for ack forever and err is tied to 0.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   ex_valid/op/dest/value/      executor op: 00 ALU, 01 LD, 10 ST, 11 NOP;
//   ex_store_data                dest 7 discards; value is ALU result or address
//   stall                        upstream must hold ex_* and not advance
//   mem_req/we/addr/wdata        memory request (held until ack)
//   mem_rdata, mem_ack           memory response (sampled only while mem_req)
//   wb_enable/dest/value         register-file writeback
//   perf_stall_cycles            saturating count of stalled cycles
//   err                          sticky access-timeout flag
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [1:0]        ex_op,
    input  logic [2:0]        ex_dest,
    input  logic [DATA_W-1:0] ex_value,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_enable,
    output logic [2:0]        wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic [15:0]       perf_stall_cycles,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [2:0] R_DISCARD = 3'd7;

    state_t     state, state_nxt;
    logic [2:0] ld_dest;
    logic       accept;
    logic       ack_seen;
    logic       timeout_hit;

    assign stall    = (state != IDLE);
    assign accept   = ex_valid && !stall;
    // Ack is only meaningful while a request is outstanding.
    assign ack_seen = mem_req && mem_ack;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // The cycle whose edge would bring the count to TIMEOUT is the abort
    // cycle; an ack in that same cycle still completes normally.
    assign timeout_hit = mem_req && !mem_ack && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (!stall)
                wait_cnt <= '0;
            else if (!mem_ack)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && ex_op == OP_LD) state_nxt = LOAD;
                if (accept && ex_op == OP_ST) state_nxt = STORE;
            end
            LOAD, STORE: begin
                if (ack_seen || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            ld_dest           <= R_DISCARD;
            wb_enable         <= 1'b0;
            wb_dest           <= R_DISCARD;
            wb_value          <= '0;
            perf_stall_cycles <= '0;
        end else begin
            wb_enable <= 1'b0;

            if (stall && perf_stall_cycles != 16'hFFFF)
                perf_stall_cycles <= perf_stall_cycles + 16'd1;

            if (state == IDLE) begin
                if (accept) begin
                    case (ex_op)
                        OP_ALU: begin
                            wb_enable <= (ex_dest != R_DISCARD);
                            wb_dest   <= ex_dest;
                            wb_value  <= ex_value;
                        end
                        OP_LD: begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= ex_value[ADDR_W-1:0];
                            ld_dest  <= ex_dest;
                        end
                        OP_ST: begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= ex_value[ADDR_W-1:0];
                            mem_wdata <= ex_store_data;
                        end
                        default: ;
                    endcase
                end
            end else if (ack_seen) begin
                mem_req <= 1'b0;
                if (state == LOAD) begin
                    wb_enable <= (ld_dest != R_DISCARD);
                    wb_dest   <= ld_dest;
                    wb_value  <= mem_rdata;
                end
            end else if (timeout_hit) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed plus randomized bench for mem_stage. Each op is
// driven as a transaction; expected outputs come from a transaction-level
// model (latency, ack delay, stall-cycle accounting, sticky error).
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [2:0]  ex_dest;
    logic [15:0] ex_value;
    logic [15:0] ex_store_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_enable;
    logic [2:0]  wb_dest;
    logic [15:0] wb_value;
    logic [15:0] perf_stall_cycles;
    logic        err;

    mem_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_dest(ex_dest),
        .ex_value(ex_value), .ex_store_data(ex_store_data),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_enable(wb_enable), .wb_dest(wb_dest), .wb_value(wb_value),
        .perf_stall_cycles(perf_stall_cycles), .err(err)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_perf = '0;
    logic        exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_perf"}, {16'd0, perf_stall_cycles}, {16'd0, exp_perf});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic alu(input logic [2:0] d, input logic [15:0] v);
        ex_valid = 1'b1; ex_op = 2'b00; ex_dest = d; ex_value = v;
        ex_store_data = 16'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        chk("alu_stall_in", {31'd0, stall}, 32'd0);
        step();
        ex_valid = 1'b0; mem_ack = 1'b0;
        chk("alu_wbe", {31'd0, wb_enable}, {31'd0, (d != 3'd7)});
        if (d != 3'd7) begin
            chk("alu_wbd", {29'd0, wb_dest}, {29'd0, d});
            chk("alu_wbv", {16'd0, wb_value}, {16'd0, v});
        end
        chk("alu_req", {31'd0, mem_req}, 32'd0);
        chk_status("alu");
    endtask

    task automatic nop();
        ex_valid = 1'($urandom_range(0, 1));
        ex_op = ex_valid ? 2'b11 : 2'($urandom);
        ex_dest = 3'($urandom); ex_value = 16'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        step();
        ex_valid = 1'b0; mem_ack = 1'b0;
        chk("nop_wbe", {31'd0, wb_enable}, 32'd0);
        chk("nop_req", {31'd0, mem_req}, 32'd0);
        chk("nop_stall", {31'd0, stall}, 32'd0);
        chk_status("nop");
    endtask

    // Load (st=0) or store (st=1) acked after dly wait cycles.
    task automatic mem_op(input logic st, input logic [2:0] d, input logic [15:0] a,
                          input logic [15:0] sd, input int dly, input logic [15:0] rd);
        int  n_cyc;
        logic to;
        to = 1'b0;
        n_cyc = dly + 1;
`ifdef MEM_STAGE_TIMEOUT_EN
        if (dly >= TO) begin
            to = 1'b1;
            n_cyc = TO;
        end
`endif
        ex_valid = 1'b1; ex_op = st ? 2'b10 : 2'b01; ex_dest = d;
        ex_value = a; ex_store_data = sd;
        chk("mem_stall_in", {31'd0, stall}, 32'd0);
        step();
        for (int k = 0; k < n_cyc; k++) begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, st});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
            if (st) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, sd});
            chk("mem_stall", {31'd0, stall}, 32'd1);
            chk("mem_wbe_busy", {31'd0, wb_enable}, 32'd0);
            mem_ack = !to && (k == n_cyc - 1);
            mem_rdata = mem_ack ? rd : 16'($urandom);
            step();
            if (exp_perf != 16'hFFFF) exp_perf++;
        end
        mem_ack = 1'b0; ex_valid = 1'b0;
        if (to) exp_err = 1'b1;
        chk("mem_req_done", {31'd0, mem_req}, 32'd0);
        chk("mem_stall_done", {31'd0, stall}, 32'd0);
        chk("mem_wbe", {31'd0, wb_enable}, {31'd0, (!st && !to && d != 3'd7)});
        if (!st && !to && d != 3'd7) begin
            chk("ld_wbd", {29'd0, wb_dest}, {29'd0, d});
            chk("ld_wbv", {16'd0, wb_value}, {16'd0, rd});
        end
        chk_status("mem");
    endtask

    initial begin
        int r, dly;
        rst = 1'b1; ex_valid = 1'b0; ex_op = 2'b00; ex_dest = 3'd0;
        ex_value = '0; ex_store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_wbe", {31'd0, wb_enable}, 32'd0);
        chk("rst_wbd", {29'd0, wb_dest}, 32'd7);
        chk("rst_wbv", {16'd0, wb_value}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk_status("rst");
        rst = 1'b0;

        alu(3'd3, 16'h1234);
        alu(3'd7, 16'h5555);
        mem_op(1'b0, 3'd2, 16'h0040, 16'h0, 3, 16'hBEEF);
        chk("ld_perf4", {16'd0, perf_stall_cycles}, 32'd4);
        mem_op(1'b1, 3'd0, 16'h0010, 16'h00A5, 0, 16'h0);
        alu(3'd5, 16'hCAFE);
        alu(3'd1, 16'h0001);
        mem_op(1'b0, 3'd7, 16'h0100, 16'h0, 1, 16'h7777);
        mem_op(1'b0, 3'd4, 16'hFFFE, 16'h0, 0, 16'h8001);
        nop();

        // Reset in the middle of a load: request drops at once, late ack ignored.
        ex_valid = 1'b1; ex_op = 2'b01; ex_dest = 3'd6; ex_value = 16'h0200;
        step(); step();
        chk("mid_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_req_async", {31'd0, mem_req}, 32'd0);
        ex_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        exp_perf = '0; exp_err = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("mid_wbe", {31'd0, wb_enable}, 32'd0);
        step();
        chk("mid_wbe2", {31'd0, wb_enable}, 32'd0);
        chk("mid_stall", {31'd0, stall}, 32'd0);
        chk_status("mid");
        mem_ack = 1'b0;

`ifdef MEM_STAGE_TIMEOUT_EN
        mem_op(1'b0, 3'd2, 16'h0300, 16'h0, TO - 1, 16'h1111);
        mem_op(1'b0, 3'd2, 16'h0304, 16'h0, TO, 16'h2222);
        alu(3'd3, 16'h3333);
        mem_op(1'b1, 3'd0, 16'h0308, 16'h4444, 2, 16'h0);
        rst = 1'b1; exp_perf = '0; exp_err = 1'b0;
        step();
        rst = 1'b0;
        chk_status("to_rst");
`endif

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 3);
            dly = $urandom_range(0, 5);
`ifdef MEM_STAGE_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) dly = $urandom_range(TO - 1, TO + 2);
`endif
            case (r)
                0: alu(3'($urandom), 16'($urandom));
                1: mem_op(1'b0, 3'($urandom), 16'($urandom), 16'h0, dly, 16'($urandom));
                2: mem_op(1'b1, 3'($urandom), 16'($urandom), 16'($urandom), dly, 16'h0);
                default: nop();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
